// File: rtl/vmem_seq.sv
// Vector memory-access sequencer: serialises a scalar or vector load/store into
// per-element accesses on one ELEM_SIZE-wide synchronous memory port.
module vmem_seq #(
  parameter int ELEM_SIZE = 8,
  parameter int VECT_SIZE = 8,
  parameter int ADDR_BITS = 6
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic                           flagMemRead_i,
  input  logic                           flagMemWrite_i,
  input  logic                           vector_i,
  input  logic [ADDR_BITS-1:0]           addr_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] wdata_i,
  input  logic [ELEM_SIZE-1:0]           mem_rdata_i,
  output logic [ADDR_BITS-1:0]           mem_addr_o,
  output logic [ELEM_SIZE-1:0]           mem_wdata_o,
  output logic                           mem_we_o,
  output logic                           mem_re_o,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] rdata_o,
  output logic                           stall_o,
  output logic                           done_o,
  output logic                           busy_o
);

  localparam int IDX_W = (VECT_SIZE > 1) ? $clog2(VECT_SIZE) : 1;
  localparam int VEC_W = ELEM_SIZE * VECT_SIZE;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state_r;
  state_t               nextState_s;
  logic [IDX_W-1:0]     idx_r;
  logic [IDX_W-1:0]     lastIdx_r;
  logic [ADDR_BITS-1:0] base_r;
  logic [VEC_W-1:0]     wdata_r;
  logic [VEC_W-1:0]     rdata_r;
  logic                 accept_s;

  // Accept decode; gated by rst_ni so nothing stalls while reset is held
  always_comb begin
    accept_s = 1'b0;
    if ((state_r == IDLE) && rst_ni && start_i && (flagMemRead_i || flagMemWrite_i)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          nextState_s = flagMemRead_i ? READ : WRITE;
        end else begin
          nextState_s = IDLE;
        end
      end
      READ: begin
        if (idx_r == lastIdx_r) begin
          nextState_s = DRAIN;
        end else begin
          nextState_s = READ;
        end
      end
      WRITE: begin
        if (idx_r == lastIdx_r) begin
          nextState_s = DONE;
        end else begin
          nextState_s = WRITE;
        end
      end
      DRAIN:   nextState_s = DONE;
      DONE:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Request latches, element index and load-data assembly
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_r     <= '0;
      lastIdx_r <= '0;
      base_r    <= '0;
      wdata_r   <= '0;
      rdata_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            base_r    <= addr_i;
            wdata_r   <= wdata_i;
            lastIdx_r <= vector_i ? IDX_W'(VECT_SIZE - 1) : '0;
            idx_r     <= '0;
            if (flagMemRead_i) begin
              rdata_r <= '0;
            end
          end
        end
        READ: begin
          idx_r <= idx_r + IDX_W'(1);
          // memory answers one cycle late, so this cycle's data belongs to the previous lane
          if (idx_r != '0) begin
            rdata_r[(idx_r - IDX_W'(1)) * ELEM_SIZE +: ELEM_SIZE] <= mem_rdata_i;
          end
        end
        DRAIN: begin
          rdata_r[lastIdx_r * ELEM_SIZE +: ELEM_SIZE] <= mem_rdata_i;
        end
        WRITE: begin
          idx_r <= idx_r + IDX_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode from registered state; address and data stay 0 without a strobe
  always_comb begin
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    stall_o     = 1'b0;
    done_o      = 1'b0;
    case (state_r)
      IDLE: stall_o = accept_s;
      READ: begin
        mem_re_o   = 1'b1;
        mem_addr_o = base_r + ADDR_BITS'(idx_r);
        stall_o    = 1'b1;
      end
      WRITE: begin
        mem_we_o    = 1'b1;
        mem_addr_o  = base_r + ADDR_BITS'(idx_r);
        mem_wdata_o = wdata_r[idx_r * ELEM_SIZE +: ELEM_SIZE];
        stall_o     = 1'b1;
      end
      DRAIN:   stall_o = 1'b1;
      DONE:    done_o  = 1'b1;
      default: stall_o = 1'b0;
    endcase
  end

  assign busy_o  = (state_r != IDLE);
  assign rdata_o = rdata_r;

endmodule

// File: tb/tb_vmem_seq.sv
// Self-checking bench for vmem_seq: directed and random loads/stores against a
// word-array reference of memory contents and cycle-count timing expectations.
module tb_vmem_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        flagMemRead_i = 1'b0;
  logic        flagMemWrite_i = 1'b0;
  logic        vector_i = 1'b0;
  logic [5:0]  addr_i = 6'd0;
  logic [63:0] wdata_i = 64'd0;
  logic [7:0]  mem_rdata_i;
  logic [5:0]  mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_we_o;
  logic        mem_re_o;
  logic [63:0] rdata_o;
  logic        stall_o;
  logic        done_o;
  logic        busy_o;

  int nChecks = 0;
  int nFail   = 0;

  logic [7:0]  memArr [64];
  logic [7:0]  refMem [64];
  logic [63:0] lastRdata = 64'd0;

  vmem_seq #(.ELEM_SIZE(8), .VECT_SIZE(8), .ADDR_BITS(6)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .flagMemRead_i(flagMemRead_i), .flagMemWrite_i(flagMemWrite_i),
    .vector_i(vector_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_rdata_i(mem_rdata_i), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .rdata_o(rdata_o),
    .stall_o(stall_o), .done_o(done_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous memory; read data is garbage unless a read was strobed last cycle
  always @(posedge clk_i) begin
    if (mem_we_o) memArr[mem_addr_o] <= mem_wdata_o;
    if (mem_re_o) mem_rdata_i <= memArr[mem_addr_o];
    else          mem_rdata_i <= 8'($urandom);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access; abortAfter>0 asserts reset after that many write strobes have landed
  task automatic runOp(input logic isRd, input logic isWr, input logic isVec,
                       input logic [5:0] base, input logic [63:0] data,
                       input bit holdStart, input int abortAfter, input string name);
    int n;
    int nWritten;
    int last;
    logic [63:0] expR;
    logic [18:0] exp;
    logic [5:0] a;
    n = isVec ? 8 : 1;
    nWritten = (abortAfter > 0) ? abortAfter : n;
    expR = 64'd0;
    if (isRd) begin
      for (int i = 0; i < n; i++) expR[i*8 +: 8] = refMem[6'(base + 6'(i))];
    end else begin
      for (int i = 0; i < nWritten; i++) refMem[6'(base + 6'(i))] = data[i*8 +: 8];
    end
    last = isRd ? n + 2 : n + 1;

    @(negedge clk_i);
    start_i = 1'b1; flagMemRead_i = isRd; flagMemWrite_i = isWr;
    vector_i = isVec; addr_i = base; wdata_i = data;
    #1;
    chk({name, "_accept"}, {62'd0, stall_o, busy_o}, {62'd0, 1'b1, 1'b0});

    for (int k = 1; k <= last; k++) begin
      @(posedge clk_i);
      if (abortAfter > 0 && k == abortAfter + 1) begin
        #2 rst_ni = 1'b0;
        #1;
        chk({name, "_rst"}, {mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, done_o, busy_o},
            19'd0);
        chk({name, "_rst_rdata"}, rdata_o, 64'd0);
        lastRdata = 64'd0;
        start_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        return;
      end
      #1;
      if (!holdStart) start_i = 1'b0;
      @(negedge clk_i);
      exp = 19'd0;
      a = 6'(base + 6'(k - 1));
      if (k <= n) begin
        exp = isRd ? {1'b1, 1'b0, a, 8'd0, 1'b1, 1'b0, 1'b1}
                   : {1'b0, 1'b1, a, data[(k-1)*8 +: 8], 1'b1, 1'b0, 1'b1};
      end else if (k < last) begin
        exp = {2'b00, 6'd0, 8'd0, 1'b1, 1'b0, 1'b1};
      end else begin
        exp = {2'b00, 6'd0, 8'd0, 1'b0, 1'b1, 1'b1};
      end
      chk($sformatf("%s_cyc%0d", name, k),
          {45'd0, mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, done_o, busy_o},
          {45'd0, exp});
    end

    if (isRd) lastRdata = expR;
    chk({name, "_rdata"}, rdata_o, lastRdata);

    start_i = 1'b0;
    @(negedge clk_i);
    chk({name, "_idle"}, {60'd0, mem_re_o, mem_we_o, stall_o, busy_o}, 64'd0);
  endtask

  initial begin
    // Reset and idle behaviour
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    start_i = 1'b1;
    #1;
    chk("idle_noflag_stall", {62'd0, stall_o, mem_re_o | mem_we_o}, 64'd0);
    @(negedge clk_i);
    chk("idle_noflag_busy", {62'd0, busy_o, mem_re_o | mem_we_o}, 64'd0);
    #2 rst_ni = 1'b0;
    #1;
    chk("reset_outputs", {45'd0, mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, done_o, busy_o},
        64'd0);
    chk("reset_rdata", rdata_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fill the whole memory so the reference and the array agree
    for (int b = 0; b < 8; b++) runOp(1'b0, 1'b1, 1'b1, 6'(b * 8), {$urandom, $urandom}, 1'b0, 0, "fill");

    runOp(1'b0, 1'b1, 1'b1, 6'd10, 64'h0706050403020100, 1'b0, 0, "vst10");
    runOp(1'b0, 1'b1, 1'b1, 6'd20, 64'hA7A6A5A4A3A2A1A0, 1'b0, 0, "vst20");
    runOp(1'b1, 1'b0, 1'b1, 6'd20, 64'd0, 1'b0, 0, "vld20");
    chk("vld20_const", rdata_o, 64'hA7A6A5A4A3A2A1A0);
    runOp(1'b0, 1'b1, 1'b0, 6'd63, 64'h5C, 1'b0, 0, "sst63");
    runOp(1'b1, 1'b0, 1'b0, 6'd63, 64'd0, 1'b0, 0, "sld63");
    chk("sld63_const", rdata_o, 64'h000000000000005C);
    runOp(1'b0, 1'b1, 1'b1, 6'd62, {$urandom, $urandom}, 1'b0, 0, "vst62");
    runOp(1'b1, 1'b1, 1'b1, 6'd62, {$urandom, $urandom}, 1'b1, 0, "both62");
    runOp(1'b1, 1'b0, 1'b1, 6'd10, 64'd0, 1'b1, 0, "vld10");

    // Store aborted by reset after three strobes, then a normal store and readback
    runOp(1'b0, 1'b1, 1'b1, 6'd40, {$urandom, $urandom}, 1'b0, 3, "abort40");
    runOp(1'b1, 1'b0, 1'b1, 6'd40, 64'd0, 1'b0, 0, "chk40");
    runOp(1'b0, 1'b1, 1'b1, 6'd40, {$urandom, $urandom}, 1'b0, 0, "vst40");
    runOp(1'b1, 1'b0, 1'b1, 6'd40, 64'd0, 1'b0, 0, "vld40");

    for (int r = 0; r < 24; r++) begin
      int kind;
      kind = $urandom_range(0, 2);
      runOp(kind != 1, kind != 0, 1'($urandom_range(0, 1)), 6'($urandom),
            {$urandom, $urandom}, 1'($urandom_range(0, 1)), 0, $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
